// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one bitwise logic unit
module logic_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 2,
    parameter int CW   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*2-1:0]  req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic [IDW-1:0]     rsp_id,
    output logic               busy,
    output logic [CW-1:0]      op_count
);

    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    logic             rsp_valid_q;
    logic [DW-1:0]    rsp_data_q;
    logic [DW-1:0]    rsp_data_d;
    logic [IDW-1:0]   rsp_id_q;
    logic [IDW-1:0]   last_q;
    logic [CW-1:0]    op_count_q;

    logic             slot_free;
    logic             drain;
    logic             grant_valid;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand_idx;
    logic [DW-1:0]    a_sel;
    logic [DW-1:0]    b_sel;
    logic [1:0]       op_sel;

    // The slot can take a new result when empty or when it drains this cycle
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign drain     = rsp_valid_q && rsp_ready;

    // Rotating-priority search starting one past the last granted requester
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        req_ready   = '0;
        if (slot_free) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand_idx = IDW'((int'(last_q) + k) % NREQ);
                if (!grant_valid && req_valid[cand_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Operand and opcode steering from the granted requester only
    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel  = req_a[i*DW +: DW];
                b_sel  = req_b[i*DW +: DW];
                op_sel = req_op[i*2 +: 2];
            end
        end
    end

    // Shared bitwise logic unit
    always_comb begin
        rsp_data_d = '0;
        case (op_sel)
            2'b00:   rsp_data_d = a_sel & b_sel;
            2'b01:   rsp_data_d = a_sel | b_sel;
            2'b10:   rsp_data_d = a_sel ^ b_sel;
            default: rsp_data_d = ~(a_sel | b_sel);
        endcase
    end

    // Response slot, round-robin pointer and saturating completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            last_q      <= LAST_RST;
            op_count_q  <= '0;
        end else begin
            if (grant_valid) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rsp_data_d;
                rsp_id_q    <= grant_idx;
                last_q      <= grant_idx;
            end else if (drain) begin
                rsp_valid_q <= 1'b0;
            end
            if (drain && (op_count_q != {CW{1'b1}})) begin
                op_count_q <= op_count_q + 1'b1;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
    assign busy      = rsp_valid_q || (|req_valid);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - directed self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [7:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         busy;
    logic [15:0]  op_count;

    logic [1:0]   s_req_valid;
    logic [1:0]   s_req_ready;
    logic [15:0]  s_req_a;
    logic [15:0]  s_req_b;
    logic [3:0]   s_req_op;
    logic         s_rsp_valid;
    logic         s_rsp_ready;
    logic [7:0]   s_rsp_data;
    logic [0:0]   s_rsp_id;
    logic         s_busy;
    logic [3:0]   s_op_count;

    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0] exp_rdy;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.NREQ(4), .DW(32), .IDW(2), .CW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    logic_unit_arbiter #(.NREQ(2), .DW(8), .IDW(1), .CW(4)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (s_req_valid),
        .req_ready (s_req_ready),
        .req_a     (s_req_a),
        .req_b     (s_req_b),
        .req_op    (s_req_op),
        .rsp_valid (s_rsp_valid),
        .rsp_ready (s_rsp_ready),
        .rsp_data  (s_rsp_data),
        .rsp_id    (s_rsp_id),
        .busy      (s_busy),
        .op_count  (s_op_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_op      = '0;
        rsp_ready   = 1'b0;
        s_req_valid = '0;
        s_req_a     = '0;
        s_req_b     = '0;
        s_req_op    = '0;
        s_rsp_ready = 1'b0;

        // reset state
        repeat (3) step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // single XOR from requester 0
        req_a[31:0]  = 32'hF0F0_F0F0;
        req_b[31:0]  = 32'hFF00_FF00;
        req_op[1:0]  = 2'b10;
        req_valid    = 4'b0001;
        rsp_ready    = 1'b1;
        #1;
        chk("xor_req_ready", req_ready, 4'b0001);
        chk("xor_busy", busy, 1);
        step();
        req_valid = '0;
        chk("xor_rsp_valid", rsp_valid, 1);
        chk("xor_rsp_data", rsp_data, 32'h0FF0_0FF0);
        chk("xor_rsp_id", rsp_id, 0);
        chk("xor_cnt_before", op_count, 0);
        step();
        chk("xor_drained", rsp_valid, 0);
        chk("xor_cnt_after", op_count, 1);

        // back-to-back round robin from a fresh pointer
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(i);
            req_b[i*32 +: 32] = 32'h0;
            req_op[i*2 +: 2]  = 2'b01;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = 4'b0001 << (c % 4);
            chk("rr_req_ready", req_ready, exp_rdy);
            step();
            chk("rr_rsp_valid", rsp_valid, 1);
            chk("rr_rsp_data", rsp_data, 64'(c % 4));
            chk("rr_rsp_id", rsp_id, 64'(c % 4));
        end
        chk("rr_cnt", op_count, 5);
        req_valid = '0;
        step();
        chk("rr_drained", rsp_valid, 0);
        chk("rr_cnt_after", op_count, 6);

        // backpressure: fill slot from requester 2, then hold rsp_ready low
        rsp_ready         = 1'b0;
        req_a[64 +: 32]   = 32'h1234_5678;
        req_b[64 +: 32]   = 32'h0;
        req_op[5:4]       = 2'b01;
        req_valid         = 4'b0100;
        step();
        chk("bp_fill_id", rsp_id, 2);
        req_a[32 +: 32]   = 32'h0000_0001;
        req_b[32 +: 32]   = 32'h0000_0002;
        req_op[3:2]       = 2'b01;
        req_a[96 +: 32]   = 32'hAAAA_0000;
        req_b[96 +: 32]   = 32'h0000_AAAA;
        req_op[7:6]       = 2'b10;
        req_valid         = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 32'h1234_5678);
            chk("bp_rsp_id", rsp_id, 2);
            chk("bp_cnt", op_count, 6);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", req_ready, 4'b1000);
        step();
        req_valid = '0;
        chk("bp_new_data", rsp_data, 32'hAAAA_AAAA);
        chk("bp_new_id", rsp_id, 3);
        chk("bp_cnt_after", op_count, 7);
        step();
        chk("bp_drain_valid", rsp_valid, 0);
        chk("bp_hold_data", rsp_data, 32'hAAAA_AAAA);
        chk("bp_hold_id", rsp_id, 3);
        chk("bp_drain_cnt", op_count, 8);

        // NOR then AND with the same operands
        req_a[31:0] = 32'h0000_FFFF;
        req_b[31:0] = 32'h00FF_00FF;
        req_op[1:0] = 2'b11;
        req_valid   = 4'b0001;
        step();
        chk("nor_data", rsp_data, 32'hFF00_0000);
        req_op[1:0] = 2'b00;
        step();
        req_valid = '0;
        chk("and_data", rsp_data, 32'h0000_00FF);
        chk("and_id", rsp_id, 0);
        chk("and_valid", rsp_valid, 1);
        step();
        chk("and_cnt", op_count, 10);

        // asynchronous reset while a response is pending
        rsp_ready  = 1'b0;
        req_valid  = 4'b0010;
        step();
        req_valid = '0;
        chk("mid_pending", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_cnt", op_count, 0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        #1;
        chk("mid_first_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        chk("mid_first_id", rsp_id, 0);
        step();

        // saturating counter on the narrow instance
        s_req_a     = 16'h003C;
        s_req_b     = 16'h000F;
        s_req_op    = 4'b0010;
        s_req_valid = 2'b01;
        s_rsp_ready = 1'b1;
        repeat (15) step();
        chk("sat_cnt_14", s_op_count, 14);
        step();
        chk("sat_cnt_15", s_op_count, 15);
        repeat (5) step();
        chk("sat_cnt_hold", s_op_count, 15);
        chk("sat_data", s_rsp_data, 8'h33);
        chk("sat_busy", s_busy, 1);
        s_req_valid = '0;
        step();
        step();
        chk("sat_idle_busy", s_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
